// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - ctl_state_e  : controller FSM encoding (RUN / DRAIN / HALT)
//   - SB_SLOTS     : scoreboard depth, one slot per stage after ID (EX, MEM, WB)
//   - SLOT_*       : slot indices inside the scoreboard vectors
//   - NOP_INSTR    : instruction word the IF/ID and ID/EX latches load on flush/bubble
//   - cmp_slot_mask: which slots take part in the RAW hazard compare
package pipe_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } ctl_state_e;

  localparam int unsigned SB_SLOTS = 3;
  localparam int unsigned SLOT_EX  = 0;
  localparam int unsigned SLOT_MEM = 1;
  localparam int unsigned SLOT_WB  = 2;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // WB is skipped when the register file forwards a same-cycle write to the read.
  function automatic logic [SB_SLOTS-1:0] cmp_slot_mask(input bit wb_bypass);
    return wb_bypass ? 3'b011 : 3'b111;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle between the pipeline datapath and the hazard/sequencing controller.
//   master : datapath side, drives ID-stage decode info, EX redirect and memory busy
//   slave  : controller side, returns stall / bubble / flush / freeze / halted / sb_busy
interface pipe_hazard_ctl_if #(
  parameter int unsigned REG_BITS = 3
);

  logic                     id_valid;
  logic [REG_BITS-1:0]      id_rs;
  logic                     id_rs_used;
  logic [REG_BITS-1:0]      id_rt;
  logic                     id_rt_used;
  logic                     id_wr_en;
  logic [REG_BITS-1:0]      id_wr_reg;
  logic                     id_halt;
  logic                     ex_pcsrc;
  logic                     mem_stall;

  logic                     stall_pc;
  logic                     bubble_ex;
  logic                     flush_ifid;
  logic                     freeze;
  logic                     halted;
  logic [(2**REG_BITS)-1:0] sb_busy;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wr_reg, id_halt, ex_pcsrc, mem_stall,
    input  stall_pc, bubble_ex, flush_ifid, freeze, halted, sb_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wr_reg, id_halt, ex_pcsrc, mem_stall,
    output stall_pc, bubble_ex, flush_ifid, freeze, halted, sb_busy
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight register-write scoreboard (EX, MEM, WB slots).
//   clk, rst     : core clock, synchronous active-high reset
//   shift_en     : advance the slots one stage (low while the pipe is frozen)
//   ex_valid_in  : instruction entering EX writes a register
//   ex_reg_in    : its destination register
//   rd_a, rd_b   : two source registers to compare against pending writes
//   hit_a_c/b_c  : a compared slot holds a pending write to rd_a / rd_b
//   busy_c       : per-register pending-write mask over all valid slots
module hazard_scoreboard
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned REG_BITS  = 3,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     ex_valid_in,
  input  logic [REG_BITS-1:0]      ex_reg_in,
  input  logic [REG_BITS-1:0]      rd_a,
  input  logic [REG_BITS-1:0]      rd_b,
  output logic                     hit_a_c,
  output logic                     hit_b_c,
  output logic [(2**REG_BITS)-1:0] busy_c
);

  localparam logic [SB_SLOTS-1:0] CMP_MASK = cmp_slot_mask(WB_BYPASS);

  logic [SB_SLOTS-1:0] slot_vld;
  logic [REG_BITS-1:0] slot_reg [SB_SLOTS];

  // Slot shift: WB <= MEM <= EX <= incoming issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld <= '0;
      for (int i = 0; i < SB_SLOTS; i++) slot_reg[i] <= '0;
    end else if (shift_en) begin
      slot_vld[SLOT_WB]  <= slot_vld[SLOT_MEM];
      slot_vld[SLOT_MEM] <= slot_vld[SLOT_EX];
      slot_vld[SLOT_EX]  <= ex_valid_in;
      slot_reg[SLOT_WB]  <= slot_reg[SLOT_MEM];
      slot_reg[SLOT_MEM] <= slot_reg[SLOT_EX];
      slot_reg[SLOT_EX]  <= ex_reg_in;
    end
  end

  // Hit compare on the selected slots; busy mask always covers every slot.
  always_comb begin
    hit_a_c = 1'b0;
    hit_b_c = 1'b0;
    busy_c  = '0;
    for (int i = 0; i < SB_SLOTS; i++) begin
      if (slot_vld[i]) begin
        busy_c[slot_reg[i]] = 1'b1;
        if (CMP_MASK[i]) begin
          if (slot_reg[i] == rd_a) hit_a_c = 1'b1;
          if (slot_reg[i] == rd_b) hit_b_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencing controller for the 5-stage core.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of pipe_hazard_ctl_if
//              in : id_valid, id_rs/_used, id_rt/_used, id_wr_en, id_wr_reg,
//                   id_halt, ex_pcsrc, mem_stall
//              out: stall_pc, bubble_ex, flush_ifid, freeze (combinational),
//                   halted (registered, sticky), sb_busy (scoreboard debug mask)
// Per-cycle priority: rst > mem_stall > DRAIN/HALT > ex_pcsrc > RAW hazard > normal.
module pipe_hazard_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned REG_BITS     = 3,
  parameter bit          WB_BYPASS    = 1'b1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  pipe_hazard_ctl_if.slave bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  ctl_state_e               state;
  logic [CNT_W-1:0]         drain_cnt;
  logic                     halted_q;

  logic                     hit_rs_c;
  logic                     hit_rt_c;
  logic                     hazard_c;
  logic                     run_c;
  logic                     issue_c;
  logic                     shift_en_c;
  logic [(2**REG_BITS)-1:0] busy_c;

  assign run_c      = (state == ST_RUN);
  assign hazard_c   = bus.id_valid &
                      ((bus.id_rs_used & hit_rs_c) | (bus.id_rt_used & hit_rt_c));
  assign issue_c    = bus.id_valid & ~hazard_c & ~bus.ex_pcsrc & run_c;
  assign shift_en_c = ~bus.mem_stall;

  hazard_scoreboard #(
    .REG_BITS  (REG_BITS),
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en_c),
    .ex_valid_in (issue_c & bus.id_wr_en & ~bus.id_halt),
    .ex_reg_in   (bus.id_wr_reg),
    .rd_a        (bus.id_rs),
    .rd_b        (bus.id_rt),
    .hit_a_c     (hit_rs_c),
    .hit_b_c     (hit_rt_c),
    .busy_c      (busy_c)
  );

  // RUN/DRAIN/HALT sequencing; everything holds while memory is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
    end else if (!bus.mem_stall) begin
      case (state)
        ST_RUN: begin
          if (issue_c && bus.id_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Latch controls act in the same cycle; redirect is ignored once HALT is in flight.
  always_comb begin
    bus.stall_pc   = 1'b0;
    bus.bubble_ex  = 1'b0;
    bus.flush_ifid = 1'b0;
    bus.freeze     = 1'b0;
    if (rst) begin
      bus.freeze = 1'b0;
    end else if (bus.mem_stall) begin
      bus.freeze = 1'b1;
    end else if (!run_c) begin
      bus.stall_pc  = 1'b1;
      bus.bubble_ex = 1'b1;
    end else if (bus.ex_pcsrc) begin
      bus.flush_ifid = 1'b1;
      bus.bubble_ex  = 1'b1;
    end else if (hazard_c) begin
      bus.stall_pc  = 1'b1;
      bus.bubble_ex = 1'b1;
    end
  end

  assign bus.halted  = halted_q;
  assign bus.sb_busy = busy_c;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
module tb_pipe_hazard_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt, ex_pcsrc, mem_stall;
  logic [2:0] id_rs, id_rt, id_wr_reg;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // dut0: WB_BYPASS=1, dut1: WB_BYPASS=0; both see the same stimulus.
  pipe_hazard_ctl_if #(.REG_BITS(3)) bif0 ();
  pipe_hazard_ctl_if #(.REG_BITS(3)) bif1 ();

  assign bif0.id_valid = id_valid;   assign bif1.id_valid = id_valid;
  assign bif0.id_rs = id_rs;         assign bif1.id_rs = id_rs;
  assign bif0.id_rs_used = id_rs_used; assign bif1.id_rs_used = id_rs_used;
  assign bif0.id_rt = id_rt;         assign bif1.id_rt = id_rt;
  assign bif0.id_rt_used = id_rt_used; assign bif1.id_rt_used = id_rt_used;
  assign bif0.id_wr_en = id_wr_en;   assign bif1.id_wr_en = id_wr_en;
  assign bif0.id_wr_reg = id_wr_reg; assign bif1.id_wr_reg = id_wr_reg;
  assign bif0.id_halt = id_halt;     assign bif1.id_halt = id_halt;
  assign bif0.ex_pcsrc = ex_pcsrc;   assign bif1.ex_pcsrc = ex_pcsrc;
  assign bif0.mem_stall = mem_stall; assign bif1.mem_stall = mem_stall;

  pipe_hazard_ctl #(.REG_BITS(3), .WB_BYPASS(1'b1), .DRAIN_CYCLES(3)) dut0 (
    .clk (clk), .rst (rst), .bus (bif0.slave)
  );
  pipe_hazard_ctl #(.REG_BITS(3), .WB_BYPASS(1'b0), .DRAIN_CYCLES(3)) dut1 (
    .clk (clk), .rst (rst), .bus (bif1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_wr_en = 0; id_wr_reg = 0; id_halt = 0; ex_pcsrc = 0; mem_stall = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); cyc(); rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] r);
    idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = r;
  endtask

  task automatic rd_rs(input logic [2:0] r);
    idle(); id_valid = 1; id_rs = r; id_rs_used = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; idle();
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    smp();
    chk("rst_ctl", 32'({bif0.stall_pc, bif0.bubble_ex, bif0.flush_ifid, bif0.freeze}), 32'h0);
    chk("rst_halted", 32'(bif0.halted), 32'h0);
    chk("rst_busy", 32'(bif0.sb_busy), 32'h0);

    // Test 1 / 6: load-use on r3, both bypass settings
    do_reset();
    wr(3'd3); smp();
    chk("t1_c0_stall", 32'(bif0.stall_pc), 32'h0);
    cyc(); rd_rs(3'd3); smp();
    chk("t1_c1_ctl0", 32'({bif0.stall_pc, bif0.bubble_ex}), 32'h3);
    chk("t1_c1_busy0", 32'(bif0.sb_busy[3]), 32'h1);
    chk("t6_c1_stall1", 32'(bif1.stall_pc), 32'h1);
    cyc(); smp();
    chk("t1_c2_ctl0", 32'({bif0.stall_pc, bif0.bubble_ex}), 32'h3);
    chk("t1_c2_busy0", 32'(bif0.sb_busy[3]), 32'h1);
    chk("t6_c2_stall1", 32'(bif1.stall_pc), 32'h1);
    cyc(); smp();
    chk("t1_c3_issue0", 32'({bif0.stall_pc, bif0.bubble_ex}), 32'h0);
    chk("t1_c3_busy0", 32'(bif0.sb_busy[3]), 32'h1);
    chk("t6_c3_stall1", 32'({bif1.stall_pc, bif1.bubble_ex}), 32'h3);
    cyc(); smp();
    chk("t6_c4_issue1", 32'(bif1.stall_pc), 32'h0);
    chk("t1_c4_busy0", 32'(bif0.sb_busy), 32'h0);

    // Test 2: redirect beats hazard; discarded instruction never enters the scoreboard
    do_reset();
    wr(3'd2); cyc();
    rd_rs(3'd2); id_wr_en = 1; id_wr_reg = 3'd4; ex_pcsrc = 1; smp();
    chk("t2_ctl", 32'({bif0.stall_pc, bif0.bubble_ex, bif0.flush_ifid}), 32'h3);
    cyc(); idle(); smp();
    chk("t2_busy_next", 32'(bif0.sb_busy), 32'h04);
    chk("t2_flush_next", 32'(bif0.flush_ifid), 32'h0);

    // Test 3: memory freeze during a pending r5 hazard
    do_reset();
    wr(3'd5); cyc();
    rd_rs(3'd5); smp();
    chk("t3_pre_stall", 32'(bif0.stall_pc), 32'h1);
    for (int k = 0; k < 4; k++) begin
      cyc(); rd_rs(3'd5); mem_stall = 1; smp();
      chk("t3_frz_ctl", 32'({bif0.freeze, bif0.stall_pc, bif0.bubble_ex}), 32'h4);
      chk("t3_frz_busy", 32'(bif0.sb_busy), 32'h20);
    end
    cyc(); rd_rs(3'd5); smp();
    chk("t3_resume", 32'({bif0.freeze, bif0.stall_pc}), 32'h1);
    cyc(); smp();
    chk("t3_issue", 32'(bif0.stall_pc), 32'h0);

    // Test 4: HALT drain
    do_reset();
    idle(); id_valid = 1; id_halt = 1; smp();
    chk("t4_c0_stall", 32'(bif0.stall_pc), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); idle(); smp();
      chk("t4_drain_ctl", 32'({bif0.stall_pc, bif0.bubble_ex}), 32'h3);
      chk("t4_drain_halted", 32'(bif0.halted), 32'h0);
    end
    cyc(); smp();
    chk("t4_c4_halted", 32'(bif0.halted), 32'h1);
    chk("t4_c4_ctl", 32'({bif0.stall_pc, bif0.bubble_ex}), 32'h3);
    cyc(); rd_rs(3'd1); ex_pcsrc = 1; id_wr_en = 1; smp();
    chk("t4_c5_halt_pcsrc", 32'({bif0.halted, bif0.flush_ifid, bif0.stall_pc}), 32'h5);
    cyc(); idle(); mem_stall = 1; smp();
    chk("t4_c6_halt_frz", 32'({bif0.halted, bif0.freeze}), 32'h3);
    cyc(); idle(); smp();
    chk("t4_c7_halted", 32'(bif0.halted), 32'h1);

    // Test 4 variant: mem_stall during DRAIN stretches it
    do_reset();
    idle(); id_valid = 1; id_halt = 1;
    cyc(); idle(); smp();
    chk("t4v_c1_stall", 32'(bif0.stall_pc), 32'h1);
    cyc(); mem_stall = 1; smp();
    chk("t4v_c2_frz", 32'({bif0.freeze, bif0.halted}), 32'h2);
    cyc(); smp();
    chk("t4v_c3_frz", 32'({bif0.freeze, bif0.halted}), 32'h2);
    cyc(); idle(); smp();
    chk("t4v_c4", 32'({bif0.stall_pc, bif0.halted}), 32'h2);
    cyc(); smp();
    chk("t4v_c5", 32'({bif0.stall_pc, bif0.halted}), 32'h2);
    cyc(); smp();
    chk("t4v_c6_halted", 32'(bif0.halted), 32'h1);

    // Test 5: reset while draining with writes in flight
    do_reset();
    wr(3'd1); cyc();
    wr(3'd2); cyc();
    wr(3'd3); cyc();
    idle(); id_valid = 1; id_halt = 1; smp();
    chk("t5_c3_busy", 32'(bif0.sb_busy), 32'h0E);
    cyc(); idle(); smp();
    chk("t5_c4_busy", 32'(bif0.sb_busy), 32'h0C);
    chk("t5_c4_stall", 32'(bif0.stall_pc), 32'h1);
    rst = 1'b1;
    cyc(); rst = 1'b0;
    rd_rs(3'd3); id_rt = 3'd1; id_rt_used = 1; id_wr_en = 1; id_wr_reg = 3'd6; smp();
    chk("t5_post_ctl", 32'({bif0.stall_pc, bif0.bubble_ex, bif0.flush_ifid, bif0.freeze}), 32'h0);
    chk("t5_post_halted", 32'(bif0.halted), 32'h0);
    chk("t5_post_busy", 32'(bif0.sb_busy), 32'h0);
    cyc(); idle(); smp();
    chk("t5_issue_busy", 32'(bif0.sb_busy), 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
